// File: rtl/dcache_pkg.sv
// Shared types and address-split helpers for the set-associative data cache.
package dcache_pkg;

  typedef enum logic [1:0] {IDLE, WB_REQ, RD_REQ} state_e;

  function automatic int calc_offset_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int calc_index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int calc_tag_w(input int sets, input int line_w);
    return 32 - calc_index_w(sets) - calc_offset_w(line_w);
  endfunction

endpackage

// File: rtl/dcache_way.sv
// One cache way: tag/valid/dirty/data per set, combinational lookup, one write
// port that either fills a whole line or merges a single 32-bit word.
module dcache_way #(
  parameter int SETS    = 16,
  parameter int LINE_W  = 256,
  parameter int INDEX_W = 4,
  parameter int TAG_W   = 23,
  parameter int WORD_W  = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INDEX_W-1:0] rd_idx_i,
  input  logic [TAG_W-1:0]   rd_tag_i,
  output logic               valid_o,
  output logic               hit_o,
  output logic               dirty_o,
  output logic [TAG_W-1:0]   tag_o,
  output logic [LINE_W-1:0]  line_o,
  input  logic [INDEX_W-1:0] wr_idx_i,
  input  logic               fill_i,
  input  logic [TAG_W-1:0]   fill_tag_i,
  input  logic [LINE_W-1:0]  fill_line_i,
  input  logic               word_we_i,
  input  logic [WORD_W-1:0]  word_sel_i,
  input  logic [31:0]        word_i
);

  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] data_q [SETS];
  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;

  assign valid_o = valid_q[rd_idx_i];
  assign dirty_o = dirty_q[rd_idx_i];
  assign tag_o   = tag_q[rd_idx_i];
  assign line_o  = data_q[rd_idx_i];
  assign hit_o   = valid_o && (tag_o == rd_tag_i);

  // Tag and data storage carry no reset; valid gates every use.
  always_ff @(posedge clk_i) begin
    if (fill_i) begin
      tag_q[wr_idx_i]  <= fill_tag_i;
      data_q[wr_idx_i] <= fill_line_i;
    end else if (word_we_i) begin
      data_q[wr_idx_i][32*word_sel_i +: 32] <= word_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_i) begin
      valid_q[wr_idx_i] <= 1'b1;
      dirty_q[wr_idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[wr_idx_i] <= 1'b1;
    end
  end

endmodule

// File: rtl/dcache_sa_controller.sv
// Set-associative write-back data-cache controller: zero-latency hits, stalls the
// pipeline on a miss while it writes back a dirty victim and refills the line.
module dcache_sa_controller
  import dcache_pkg::*;
#(
  parameter int SETS   = 16,
  parameter int WAYS   = 2,
  parameter int LINE_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [31:0]       mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o
);

  localparam int OFFSET_W = calc_offset_w(LINE_W);
  localparam int INDEX_W  = calc_index_w(SETS);
  localparam int TAG_W    = calc_tag_w(SETS, LINE_W);
  localparam int WORD_W   = OFFSET_W - 2;
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [INDEX_W-1:0] cpu_idx;
  logic [TAG_W-1:0]   cpu_tag;
  logic [WORD_W-1:0]  cpu_word;
  logic               req, req_rd, req_wr;
  logic [1:0]         unused_addr;

  assign cpu_idx     = cpu_addr_i[OFFSET_W +: INDEX_W];
  assign cpu_tag     = cpu_addr_i[31 -: TAG_W];
  assign cpu_word    = cpu_addr_i[2 +: WORD_W];
  assign unused_addr = cpu_addr_i[1:0];
  assign req_wr      = cpu_MemWrite_i;
  assign req_rd      = cpu_MemRead_i & ~cpu_MemWrite_i;
  assign req         = cpu_MemRead_i | cpu_MemWrite_i;

  state_e             state_q;
  logic               mem_en_q, mem_wr_q;
  logic [31:0]        mem_addr_q;
  logic [LINE_W-1:0]  mem_data_q;
  logic [TAG_W-1:0]   cap_tag_q;
  logic [INDEX_W-1:0] cap_idx_q;
  logic [WORD_W-1:0]  cap_word_q;
  logic [31:0]        cap_data_q;
  logic               cap_wr_q;
  logic [WAY_W-1:0]   victim_q;
  logic [SETS-1:0][WAY_W-1:0] rr_q;

  logic [WAYS-1:0]              way_valid, way_hit, way_dirty, fill_en, word_en;
  logic [WAYS-1:0][TAG_W-1:0]   way_tag;
  logic [WAYS-1:0][LINE_W-1:0]  way_line;
  logic [INDEX_W-1:0]           wr_idx;
  logic [LINE_W-1:0]            fill_line_d;

  assign wr_idx = (state_q == IDLE) ? cpu_idx : cap_idx_q;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign fill_en[w] = (state_q == RD_REQ) && mem_ack_i && (victim_q == WAY_W'(w));
    assign word_en[w] = (state_q == IDLE) && req_wr && way_hit[w];

    dcache_way #(
      .SETS(SETS), .LINE_W(LINE_W), .INDEX_W(INDEX_W), .TAG_W(TAG_W), .WORD_W(WORD_W)
    ) u_way (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .rd_idx_i    (cpu_idx),
      .rd_tag_i    (cpu_tag),
      .valid_o     (way_valid[w]),
      .hit_o       (way_hit[w]),
      .dirty_o     (way_dirty[w]),
      .tag_o       (way_tag[w]),
      .line_o      (way_line[w]),
      .wr_idx_i    (wr_idx),
      .fill_i      (fill_en[w]),
      .fill_tag_i  (cap_tag_q),
      .fill_line_i (fill_line_d),
      .word_we_i   (word_en[w]),
      .word_sel_i  (cpu_word),
      .word_i      (cpu_data_i)
    );
  end

  logic              hit, vic_valid, vic_dirty;
  logic [LINE_W-1:0] hit_line, vic_line;
  logic [TAG_W-1:0]  vic_tag;
  logic [WAY_W-1:0]  victim;

  // Lowest invalid way wins; otherwise the set's round-robin pointer.
  always_comb begin
    hit       = 1'b0;
    hit_line  = '0;
    victim    = rr_q[cpu_idx];
    vic_valid = 1'b0;
    vic_dirty = 1'b0;
    vic_tag   = '0;
    vic_line  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) victim = WAY_W'(w);
    end
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) begin
        hit      = 1'b1;
        hit_line = way_line[w];
      end
      if (victim == WAY_W'(w)) begin
        vic_valid = way_valid[w];
        vic_dirty = way_dirty[w];
        vic_tag   = way_tag[w];
        vic_line  = way_line[w];
      end
    end
  end

  // A pending store lands in the refilled line; the replayed hit then marks it dirty.
  always_comb begin
    fill_line_d = mem_data_i;
    if (cap_wr_q) fill_line_d[32*cap_word_q +: 32] = cap_data_q;
  end

  assign cpu_stall_o  = (state_q != IDLE) || (req && !hit);
  assign cpu_data_o   = ((state_q == IDLE) && req_rd && hit) ? hit_line[32*cpu_word +: 32] : '0;
  assign mem_enable_o = mem_en_q;
  assign mem_write_o  = mem_wr_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      mem_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      cap_tag_q  <= '0;
      cap_idx_q  <= '0;
      cap_word_q <= '0;
      cap_data_q <= '0;
      cap_wr_q   <= 1'b0;
      victim_q   <= '0;
      rr_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (req && !hit) begin
          cap_tag_q  <= cpu_tag;
          cap_idx_q  <= cpu_idx;
          cap_word_q <= cpu_word;
          cap_data_q <= cpu_data_i;
          cap_wr_q   <= req_wr;
          victim_q   <= victim;
          mem_en_q   <= 1'b1;
          if (vic_valid && vic_dirty) begin
            state_q    <= WB_REQ;
            mem_wr_q   <= 1'b1;
            mem_addr_q <= {vic_tag, cpu_idx, {OFFSET_W{1'b0}}};
            mem_data_q <= vic_line;
          end else begin
            state_q    <= RD_REQ;
            mem_wr_q   <= 1'b0;
            mem_addr_q <= {cpu_tag, cpu_idx, {OFFSET_W{1'b0}}};
          end
        end
        WB_REQ: if (mem_ack_i) begin
          state_q    <= RD_REQ;
          mem_wr_q   <= 1'b0;
          mem_addr_q <= {cap_tag_q, cap_idx_q, {OFFSET_W{1'b0}}};
          mem_data_q <= '0;
        end
        RD_REQ: if (mem_ack_i) begin
          state_q  <= IDLE;
          mem_en_q <= 1'b0;
          rr_q[cap_idx_q] <= (rr_q[cap_idx_q] == WAY_W'(WAYS - 1)) ? '0 : rr_q[cap_idx_q] + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_sa_controller.sv
// Bench for dcache_sa_controller: a 2-way and a 1-way instance against a latency
// model of line memory, a word-level reference image and a read-data scoreboard.
module tb_dcache_sa_controller;

  localparam int LAT = 4;  // ack is raised in the LAT-th cycle of a request
  localparam logic [31:0] NONE = 32'hFFFF_FFFF;

  typedef struct {
    int          d;
    bit          rst;
    logic [31:0] addr;
    bit          rd;
    bit          wr;
    logic [31:0] wdata;
    int          st;
    logic [31:0] wb;
    logic [31:0] rda;
  } vec_t;

  typedef struct {
    int          d;
    logic        wr;
    logic [31:0] addr;
  } log_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [31:0]  addr [2], wdata [2], rdata [2], maddr [2];
  logic         rd [2], wr [2], stall [2], men [2], mwr [2], mack [2];
  logic [255:0] mdi [2], mdo [2];

  always #5 clk = ~clk;

  dcache_sa_controller #(.SETS(16), .WAYS(2), .LINE_W(256)) dut0 (
    .clk_i(clk), .rst_i(rst_n), .cpu_addr_i(addr[0]), .cpu_data_i(wdata[0]),
    .cpu_MemRead_i(rd[0]), .cpu_MemWrite_i(wr[0]), .cpu_data_o(rdata[0]),
    .cpu_stall_o(stall[0]), .mem_data_i(mdi[0]), .mem_ack_i(mack[0]),
    .mem_data_o(mdo[0]), .mem_addr_o(maddr[0]), .mem_enable_o(men[0]), .mem_write_o(mwr[0]));

  dcache_sa_controller #(.SETS(16), .WAYS(1), .LINE_W(256)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .cpu_addr_i(addr[1]), .cpu_data_i(wdata[1]),
    .cpu_MemRead_i(rd[1]), .cpu_MemWrite_i(wr[1]), .cpu_data_o(rdata[1]),
    .cpu_stall_o(stall[1]), .mem_data_i(mdi[1]), .mem_ack_i(mack[1]),
    .mem_data_o(mdo[1]), .mem_addr_o(maddr[1]), .mem_enable_o(men[1]), .mem_write_o(mwr[1]));

  int n_chk = 0;
  int n_pass = 0;

  logic [255:0] backing [logic [31:0]];
  logic [31:0]  gold [logic [31:0]];
  logic [31:0]  exp_q [$];
  log_t         log_q [$];
  vec_t         vq [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chkl(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h0000_0400) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [255:0] get_line(input logic [31:0] la);
    logic [255:0] ln;
    if (backing.exists(la)) return backing[la];
    for (int w = 0; w < 8; w++) ln[32*w +: 32] = init_word(la + 32'(4 * w));
    return ln;
  endfunction

  // CPU-visible value: latest store, else whatever memory holds.
  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    logic [255:0] ln;
    if (gold.exists(a)) return gold[a];
    ln = get_line(a & ~32'h1F);
    return ln[32*a[4:2] +: 32];
  endfunction

  // Memory model: logs each request, checks it stays stable, acks in cycle LAT.
  int           cnt [2];
  logic [31:0]  h_addr [2];
  logic         h_wr [2];
  logic [255:0] h_data [2];
  always @(posedge clk) begin
    #1;
    for (int g = 0; g < 2; g++) begin
      mack[g] = 1'b0;
      if (!rst_n) cnt[g] = 0;
      else if (men[g]) begin
        if (cnt[g] == 0) begin
          h_addr[g] = maddr[g];
          h_wr[g]   = mwr[g];
          h_data[g] = mdo[g];
          log_q.push_back('{g, mwr[g], maddr[g]});
        end else begin
          chk("mem_addr_stable", maddr[g], h_addr[g]);
          chk("mem_write_stable", 32'(mwr[g]), 32'(h_wr[g]));
          if (h_wr[g]) chkl("mem_data_stable", mdo[g], h_data[g]);
        end
        cnt[g]++;
        if (cnt[g] == LAT) begin
          mack[g] = 1'b1;
          cnt[g]  = 0;
          if (h_wr[g]) backing[h_addr[g]] = h_data[g];
          else mdi[g] = get_line(h_addr[g]);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      rd[g] = 1'b0; wr[g] = 1'b0; addr[g] = '0; wdata[g] = '0;
    end
    gold.delete();
    exp_q.delete();
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("rst_mem_enable", 32'(men[g]), 32'd0);
      chk("rst_mem_write", 32'(mwr[g]), 32'd0);
      chk("rst_mem_addr", maddr[g], 32'd0);
      chkl("rst_mem_data", mdo[g], 256'd0);
      chk("rst_stall", 32'(stall[g]), 32'd0);
      chk("rst_cpu_data", rdata[g], 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic acc(input vec_t v);
    int stalls;
    int n_exp;
    int k;
    logic [31:0] exp_d;
    log_q.delete();
    @(negedge clk);
    addr[v.d] = v.addr; rd[v.d] = v.rd; wr[v.d] = v.wr; wdata[v.d] = v.wdata;
    if (v.rd && !v.wr) exp_q.push_back(gold_rd(v.addr));
    if (v.wr) gold[v.addr] = v.wdata;
    stalls = 0;
    #1;
    while (stall[v.d] && stalls < 40) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    chk($sformatf("stall_cycles@%h", v.addr), stalls, v.st);
    if (v.rd && !v.wr) begin
      exp_d = exp_q.pop_front();
      chk($sformatf("rdata@%h", v.addr), rdata[v.d], exp_d);
    end
    n_exp = int'(v.wb != NONE) + int'(v.rda != NONE);
    chk($sformatf("traffic_count@%h", v.addr), log_q.size(), n_exp);
    k = 0;
    if (v.wb != NONE && log_q.size() > k) begin
      chk("wb_addr", log_q[k].addr, v.wb);
      chk("wb_is_write", 32'(log_q[k].wr), 32'd1);
      k++;
    end
    if (v.rda != NONE && log_q.size() > k) begin
      chk("rd_addr", log_q[k].addr, v.rda);
      chk("rd_is_read", 32'(log_q[k].wr), 32'd0);
    end
    @(posedge clk);
    #1;
    rd[v.d] = 1'b0;
    wr[v.d] = 1'b0;
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    // d, rst, addr, rd, wr, wdata, stall cycles, write-back addr, refill addr
    vq.push_back('{0, 1'b1, 32'h000, 1'b1, 1'b0, 32'h0, 5, NONE, 32'h000});
    vq.push_back('{0, 1'b0, 32'h400, 1'b1, 1'b0, 32'h0, 5, NONE, 32'h400});
    vq.push_back('{0, 1'b0, 32'h404, 1'b0, 1'b1, 32'h1234_5678, 0, NONE, NONE});
    vq.push_back('{0, 1'b0, 32'h404, 1'b1, 1'b0, 32'h0, 0, NONE, NONE});
    vq.push_back('{0, 1'b1, 32'h000, 1'b1, 1'b0, 32'h0, 5, NONE, 32'h000});
    vq.push_back('{0, 1'b0, 32'h000, 1'b0, 1'b1, 32'hCAFE_F00D, 0, NONE, NONE});
    vq.push_back('{0, 1'b0, 32'h200, 1'b1, 1'b0, 32'h0, 5, NONE, 32'h200});
    vq.push_back('{0, 1'b0, 32'h400, 1'b1, 1'b0, 32'h0, 9, 32'h000, 32'h400});
    vq.push_back('{0, 1'b0, 32'h400, 1'b1, 1'b0, 32'h0, 0, NONE, NONE});
    vq.push_back('{0, 1'b0, 32'h600, 1'b1, 1'b0, 32'h0, 5, NONE, 32'h600});
    vq.push_back('{0, 1'b0, 32'h000, 1'b1, 1'b0, 32'h0, 5, NONE, 32'h000});
    vq.push_back('{0, 1'b0, 32'h01C, 1'b0, 1'b1, 32'h0BAD_F00D, 0, NONE, NONE});
    vq.push_back('{0, 1'b0, 32'h01C, 1'b1, 1'b0, 32'h0, 0, NONE, NONE});
    vq.push_back('{0, 1'b0, 32'h3E0, 1'b1, 1'b0, 32'h0, 5, NONE, 32'h3E0});
    vq.push_back('{0, 1'b0, 32'h3E4, 1'b1, 1'b1, 32'h7766_5544, 0, NONE, NONE});
    vq.push_back('{0, 1'b0, 32'h3E4, 1'b1, 1'b0, 32'h0, 0, NONE, NONE});
    vq.push_back('{0, 1'b0, 32'h200, 1'b1, 1'b0, 32'h0, 5, NONE, 32'h200});
    vq.push_back('{0, 1'b0, 32'h81C, 1'b0, 1'b1, 32'h1357_9BDF, 9, 32'h000, 32'h800});
    vq.push_back('{0, 1'b0, 32'h81C, 1'b1, 1'b0, 32'h0, 0, NONE, NONE});
    vq.push_back('{0, 1'b0, 32'h01C, 1'b1, 1'b0, 32'h0, 5, NONE, 32'h000});
    // single-way instance: alternating lines in one set always evict each other
    vq.push_back('{1, 1'b1, 32'h000, 1'b1, 1'b0, 32'h0, 5, NONE, 32'h000});
    vq.push_back('{1, 1'b0, 32'h200, 1'b1, 1'b0, 32'h0, 5, NONE, 32'h200});
    vq.push_back('{1, 1'b0, 32'h000, 1'b1, 1'b0, 32'h0, 5, NONE, 32'h000});
    vq.push_back('{1, 1'b0, 32'h200, 1'b1, 1'b0, 32'h0, 5, NONE, 32'h200});

    foreach (vq[i]) begin
      if (vq[i].rst) do_reset();
      acc(vq[i]);
    end

    // Reset arriving while a write-back waits for its ack.
    do_reset();
    acc('{0, 1'b0, 32'h000, 1'b1, 1'b0, 32'h0, 5, NONE, 32'h000});
    acc('{0, 1'b0, 32'h000, 1'b0, 1'b1, 32'h1111_2222, 0, NONE, NONE});
    acc('{0, 1'b0, 32'h200, 1'b1, 1'b0, 32'h0, 5, NONE, 32'h200});
    @(negedge clk);
    addr[0] = 32'h400;
    rd[0]   = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (!(men[0] && mwr[0]) && k < 20);
    chk("wb_started", 32'({men[0], mwr[0]}), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("abort_mem_enable", 32'(men[0]), 32'd0);
    chk("abort_mem_write", 32'(mwr[0]), 32'd0);
    rd[0] = 1'b0;
    gold.delete();
    #1;
    chk("abort_stall", 32'(stall[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    acc('{0, 1'b0, 32'h000, 1'b1, 1'b0, 32'h0, 5, NONE, 32'h000});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dcache_sa_controller.md
# dcache_sa_controller

Parametrised set-associative write-back data-cache controller; next generation of the direct-mapped `dcache_controller` in the MEM stage of the pipelined CPU. Sits between EX_MEM/MEM_WB (CPU side) and the 256-bit off-chip data memory (memory side). Holds tag, valid, dirty and data arrays internally. Hides miss latency from the pipeline via `cpu_stall_o`, which drives every pipeline register stall input. Adds configurable sets and ways, invalid-first plus round-robin replacement, and dirty-victim write-back.

## Interface

Parameters:
- `SETS`, 16: number of sets; power of two, 2..256.
- `WAYS`, 2: associativity; 1, 2 or 4.
- `LINE_W`, 256: line width in bits; fixed equal to memory bus width; power of two ≥ 64.

Ports:
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset; asynchronous, active-low.
- `cpu_addr_i` in 32: byte address (ALU result); bits [1:0] ignored.
- `cpu_data_i` in 32: store data.
- `cpu_MemRead_i` in 1: load request.
- `cpu_MemWrite_i` in 1: store request; wins over `cpu_MemRead_i` if both are high.
- `cpu_data_o` out 32: load data; valid in any cycle with a read request and `cpu_stall_o`=0.
- `cpu_stall_o` out 1: freeze the pipeline.
- `mem_data_i` in LINE_W: refill line.
- `mem_ack_i` in 1: one-cycle acknowledge of the current memory request.
- `mem_data_o` out LINE_W: write-back line.
- `mem_addr_o` out 32: line-aligned memory address.
- `mem_enable_o` out 1: memory request valid.
- `mem_write_o` out 1: 1 = write-back, 0 = refill.

## Operation

- Address split: offset = [log2(LINE_W/8)-1:0], word = offset[.. :2], index = next log2(SETS) bits, tag = remaining upper bits.
- Hit: the request is valid and any way in the indexed set has valid=1 and a matching tag.
  - Read hit: combinational word select to `cpu_data_o`.
  - Write hit: merge the 32-bit word at the clock edge and set that way's dirty bit.
  - A hit never stalls.
- States:
  - IDLE: on a request miss, capture address, store data and request type; choose the victim; go to WB_REQ if the victim is valid and dirty, else RD_REQ.
  - WB_REQ: `mem_enable_o`=1, `mem_write_o`=1, `mem_addr_o`={victim tag, index, 0}, `mem_data_o`=victim line. On `mem_ack_i`, go to RD_REQ.
  - RD_REQ: `mem_enable_o`=1, `mem_write_o`=0, `mem_addr_o`={captured tag, index, 0}. On `mem_ack_i`, write `mem_data_i` into the victim way, set valid=1 and dirty=0, update the tag, and go to IDLE.
  - The pending access then hits in IDLE. A store hit sets dirty.
- Victim choice: lowest-numbered invalid way first; otherwise the per-set round-robin pointer. The pointer advances (mod WAYS) on every refill of that set. For WAYS=1 the victim is always way 0.
- `cpu_stall_o` = (IDLE and request and miss) or (state ≠ IDLE).
- Memory outputs stay stable from request start until the ack cycle. `mem_ack_i` outside WB_REQ/RD_REQ is ignored.
- While stalled, the CPU holds its address and data stable; the controller uses the captured copies regardless.

## Timing

- Reset values: state IDLE; all valid, dirty and round-robin pointers 0; `mem_enable_o`=0, `mem_write_o`=0, `mem_addr_o`=0, `mem_data_o`=0; `cpu_stall_o`=0 and `cpu_data_o`=0 with no request. Data and tag arrays are not reset.
- Reset asserted mid-miss aborts the transaction immediately (asynchronous): `mem_enable_o` drops at once, and the captured request is discarded.
- Hit latency is 0 cycles.
- Clean miss: stall cycles = 1 (IDLE detect) + cycles in RD_REQ up to and including the ack. Stall drops in the cycle after the ack.
- Dirty miss adds the WB_REQ cycles up to and including its ack.
- Back-to-back misses: no idle gap is required beyond the single IDLE hit cycle.

## Structure

- Package `dcache_pkg` holds:
  - state enum (IDLE, WB_REQ, RD_REQ);
  - localparam functions for OFFSET_W, INDEX_W and TAG_W from SETS and LINE_W.
- Sub-module `dcache_way`, instantiated WAYS times. Each instance holds the tag, valid, dirty and data arrays for one way, with a combinational read port (hit, line, dirty, tag) and one write port (full-line fill or word merge).
- The top level holds the FSM, victim selection, round-robin pointers and capture registers.

## Test plan

Defaults are SETS=16, WAYS=2 unless noted.

1. Cold read 0x0000_0400 with `mem_ack_i` 3 cycles after the request and a line whose word0 is 0xDEADBEEF:
   - `mem_enable_o`=1, `mem_write_o`=0, `mem_addr_o`=0x400 until the ack;
   - stall drops the cycle after the ack;
   - `cpu_data_o`=0xDEADBEEF.
2. Store 0x12345678 to 0x404 after test 1, then load 0x404:
   - no stall on either access;
   - load returns 0x12345678;
   - no memory traffic.
3. Fill set 0 with 0x000 (made dirty by a store) and 0x200, then read 0x400:
   - WB_REQ with `mem_addr_o`=0x000, `mem_write_o`=1 and the stored word in `mem_data_o`;
   - then RD_REQ for 0x400.
4. Access 0x400 again, then 0x600:
   - invalid-first is exhausted, so the round-robin pointer now selects way 1 (clean);
   - direct RD_REQ with no write-back.
5. `rst_i` low during a WB_REQ wait:
   - `mem_enable_o`=0 in the same cycle;
   - after release, a read of 0x000 misses (valid cleared).
6. WAYS=1, alternating reads of 0x000 and 0x200:
   - every access misses and evicts the other line;
   - no write-backs, since both lines are clean.
